// File: rtl/encoder_pkg.sv
// Shared types and helpers for the pending-set priority encoder.
package encoder_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Index width that never collapses to zero, even for tiny vectors.
    function automatic int clog2_min1(input int n);
        int r;
        r = (n <= 2) ? 1 : $clog2(n);
        return r;
    endfunction

endpackage

// File: rtl/encoder_pend_prio_sel.sv
// Combinational highest-bit selector used by encoder_pend.
// Produces the index of the highest set bit and a one-hot mask of that bit.
module prio_sel
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o
);

    // Scan upward so the last (highest) set bit wins.
    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                any_o       = 1'b1;
                idx_o       = IDX_W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_pend.sv
// Registered priority encoder with a pending request set.
// Request pulses are merged into a pending set; one index at a time is
// offered through a valid/ready handshake, highest bit first.
// Optional multi-hot sample flag on oErr: define ENCODER_ONEHOT_CHECK_EN.
module encoder_pend
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = clog2_min1(WIDTH)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    input  logic             iReady,
    output logic             oValid,
    output logic [IDX_W-1:0] oData,
    output logic [WIDTH-1:0] oPending,
    output logic             oErr
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] data_q, data_d;
    logic [WIDTH-1:0] merged;
    logic             sel_any;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_onehot;
    logic             load;

    // New requests join the pending set before selection, so a request
    // arriving in a transfer cycle competes in that same selection.
    assign merged = pend_q | iData;

    // The output register may only be refilled when empty or being drained.
    assign load = (state_q == ST_EMPTY) || iReady;

    prio_sel #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .vec_i    (merged),
        .any_o    (sel_any),
        .idx_o    (sel_idx),
        .onehot_o (sel_onehot)
    );

    // FSM state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: on every load, hold exactly when something is left to grant.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = sel_any ? ST_HOLD : ST_EMPTY;
        end
    end

    // FSM outputs.
    always_comb begin
        oValid = (state_q == ST_HOLD);
    end

    // Next pending set and output index; the granted bit leaves the pending set.
    always_comb begin
        pend_d = merged;
        data_d = data_q;
        if (load && sel_any) begin
            data_d = sel_idx;
            pend_d = merged & ~sel_onehot;
        end
    end

    // Pending set and output index registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pend_q <= '0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign oData    = data_q;
    assign oPending = pend_q;

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic err_q;
    logic multi_hot;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(iData & (iData - WIDTH'(1)));

    // One-cycle flag after any multi-hot request sample.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= multi_hot;
        end
    end

    assign oErr = err_q;
`else
    assign oErr = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_pend.sv
// Self-checking bench for encoder_pend (WIDTH=8).
module tb_encoder_pend;

    logic       clk;
    logic       iRst;
    logic [7:0] iData;
    logic       iReady;
    logic       oValid;
    logic [2:0] oData;
    logic [7:0] oPending;
    logic       oErr;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_idx;

    encoder_pend #(.WIDTH(8)) dut (
        .iClk     (clk),
        .iRst     (iRst),
        .iData    (iData),
        .iReady   (iReady),
        .oValid   (oValid),
        .oData    (oData),
        .oPending (oPending),
        .oErr     (oErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every transfer pops the next index the tests pushed.
    always @(negedge clk) begin
        if (!iRst && oValid && iReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL emit_unexpected: got index %0d, expected no transfer", oData);
            end else begin
                exp_idx = exp_q.pop_front();
                if (oData !== exp_idx) begin
                    errors++;
                    $display("FAIL emit_order: got index %0d, expected %0d", oData, exp_idx);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point for the current cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        iRst = 1'b1; iData = 8'hFF; iReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            checks++;
            if ({oValid, oData, oPending, oErr} !== 13'd0) begin
                errors++;
                $display("FAIL reset_state: v=%0b d=%0d p=%02h e=%0b, expected all zero",
                         oValid, oData, oPending, oErr);
            end
        end
        tick(); iRst = 1'b0; iData = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick(); mid();
            checks++;
            if (oValid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_valid: got %0b, expected 0", oValid);
            end
        end
    endtask

    task automatic test_single();
        tick(); iData = 8'h20; iReady = 1'b1; exp_q.push_back(3'd5);
        tick(); iData = 8'h00; mid();
        checks++;
        if (oValid !== 1'b1 || oData !== 3'd5) begin
            errors++;
            $display("FAIL single_grant: v=%0b d=%0d, expected v=1 d=5", oValid, oData);
        end
        tick(); mid();
        checks++;
        if (oValid !== 1'b0 || oPending !== 8'h00) begin
            errors++;
            $display("FAIL single_drain: v=%0b p=%02h, expected v=0 p=00", oValid, oPending);
        end
    endtask

    task automatic test_multi_hot();
        logic [2:0] idx_t[3];
        logic [7:0] pnd_t[3];
        idx_t = '{3'd7, 3'd2, 3'd0};
        pnd_t = '{8'h05, 8'h01, 8'h00};
        tick(); iData = 8'h85; iReady = 1'b1;
        exp_q.push_back(3'd7); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        tick(); iData = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            mid();
            checks++;
            if (oValid !== 1'b1 || oData !== idx_t[i] || oPending !== pnd_t[i]) begin
                errors++;
                $display("FAIL multi_step%0d: v=%0b d=%0d p=%02h, expected v=1 d=%0d p=%02h",
                         i, oValid, oData, oPending, idx_t[i], pnd_t[i]);
            end
        end
        tick(); mid();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL multi_end: v=%0b, expected 0", oValid);
        end
    endtask

    task automatic test_backpressure();
        tick(); iReady = 1'b0; iData = 8'h10;
        exp_q.push_back(3'd4); exp_q.push_back(3'd7);
        tick(); iData = 8'h80; mid();
        checks++;
        if (oValid !== 1'b1 || oData !== 3'd4) begin
            errors++;
            $display("FAIL bp_first: v=%0b d=%0d, expected v=1 d=4", oValid, oData);
        end
        tick(); iData = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            mid();
            checks++;
            if (oData !== 3'd4 || oPending !== 8'h80 || oValid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%0b d=%0d p=%02h, expected v=1 d=4 p=80",
                         i, oValid, oData, oPending);
            end
        end
        tick(); iReady = 1'b1;
        tick(); mid();
        checks++;
        if (oValid !== 1'b1 || oData !== 3'd7 || oPending !== 8'h00) begin
            errors++;
            $display("FAIL bp_second: v=%0b d=%0d p=%02h, expected v=1 d=7 p=00",
                     oValid, oData, oPending);
        end
        tick(); mid();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: v=%0b, expected 0", oValid);
        end
    endtask

    task automatic test_simultaneous();
        // Held index 0 accepted while index 3 is requested in the same cycle.
        tick(); iReady = 1'b1; iData = 8'h01;
        exp_q.push_back(3'd0); exp_q.push_back(3'd3);
        tick(); iData = 8'h08; mid();
        checks++;
        if (oData !== 3'd0) begin
            errors++;
            $display("FAIL simul_first: d=%0d, expected 0", oData);
        end
        tick(); iData = 8'h00; mid();
        checks++;
        if (oValid !== 1'b1 || oData !== 3'd3 || oPending !== 8'h00) begin
            errors++;
            $display("FAIL simul_next: v=%0b d=%0d p=%02h, expected v=1 d=3 p=00",
                     oValid, oData, oPending);
        end
        tick(); mid();
    endtask

    task automatic test_rerequest();
        // Held index 2 requested again twice (coalesced), then served once more.
        tick(); iReady = 1'b0; iData = 8'h04;
        exp_q.push_back(3'd2); exp_q.push_back(3'd2);
        tick(); iData = 8'h04;
        tick(); iData = 8'h04;
        tick(); iData = 8'h00; mid();
        checks++;
        if (oData !== 3'd2 || oPending !== 8'h04) begin
            errors++;
            $display("FAIL rereq_hold: d=%0d p=%02h, expected d=2 p=04", oData, oPending);
        end
        iReady = 1'b1;
        tick(); mid();
        checks++;
        if (oValid !== 1'b1 || oData !== 3'd2 || oPending !== 8'h00) begin
            errors++;
            $display("FAIL rereq_again: v=%0b d=%0d p=%02h, expected v=1 d=2 p=00",
                     oValid, oData, oPending);
        end
        tick(); mid();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL rereq_end: v=%0b, expected 0", oValid);
        end
    endtask

    task automatic test_reset_mid();
        tick(); iReady = 1'b0; iData = 8'h4C;
        tick(); iData = 8'h00; mid();
        checks++;
        if (oValid !== 1'b1 || oData !== 3'd6 || oPending !== 8'h0C) begin
            errors++;
            $display("FAIL rstmid_setup: v=%0b d=%0d p=%02h, expected v=1 d=6 p=0C",
                     oValid, oData, oPending);
        end
        tick(); iRst = 1'b1; iData = 8'h30;
        tick(); iRst = 1'b0; iData = 8'h00; iReady = 1'b1; mid();
        checks++;
        if (oValid !== 1'b0 || oPending !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_clear: v=%0b p=%02h, expected v=0 p=00", oValid, oPending);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            checks++;
            if (oValid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: v=%0b d=%0d, expected v=0", i, oValid, oData);
            end
        end
    endtask

    task automatic test_err_flag();
        logic exp_err;
`ifdef ENCODER_ONEHOT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tick(); iReady = 1'b1; iData = 8'h03;
        exp_q.push_back(3'd1); exp_q.push_back(3'd0);
        tick(); iData = 8'h00; mid();
        checks++;
        if (oErr !== exp_err || oData !== 3'd1 || oPending !== 8'h01) begin
            errors++;
            $display("FAIL err_first: e=%0b d=%0d p=%02h, expected e=%0b d=1 p=01",
                     oErr, oData, oPending, exp_err);
        end
        tick(); mid();
        checks++;
        if (oErr !== 1'b0 || oData !== 3'd0 || oValid !== 1'b1) begin
            errors++;
            $display("FAIL err_second: e=%0b v=%0b d=%0d, expected e=0 v=1 d=0",
                     oErr, oValid, oData);
        end
        tick(); mid();
        checks++;
        if (oValid !== 1'b0 || oErr !== 1'b0) begin
            errors++;
            $display("FAIL err_end: v=%0b e=%0b, expected 0 0", oValid, oErr);
        end
    endtask

    initial begin
        iRst = 1'b1; iData = 8'h00; iReady = 1'b0;
        test_reset();
        test_single();
        test_multi_hot();
        test_backpressure();
        test_simultaneous();
        test_rerequest();
        test_reset_mid();
        test_err_flag();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d indices never emitted, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_pend.md
# encoder_pend

Parametrised, registered priority encoder with request queuing. It generalises the combinational 8-to-3 one-hot encoder to WIDTH inputs and accepts multi-hot input. Request pulses are latched into a pending set. One index is emitted at a time, highest set bit first, through a valid/ready handshake. The block sits between event or interrupt sources and a consumer that services one source index per transfer.

## Interface
- WIDTH, 8, number of request lines; minimum 2.
- IDX_W, $clog2(WIDTH), localparam; width of the index output.
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  reset; synchronous, active-high.
- iData  input  WIDTH  request pulses, sampled every cycle; any number of bits may be set.
- iReady  input  1  consumer accepts oData this cycle.
- oValid  output  1  oData holds a valid index.
- oData  output  IDX_W  index of the granted request.
- oPending  output  WIDTH  registered pending set; excludes the index currently held in oData.
- oErr  output  1  multi-hot sample flag; only active when ENCODER_ONEHOT_CHECK_EN is defined.

## Operation
- State: pending register P[WIDTH-1:0]; output register (oValid, oData).
- Two-state FSM.
  - EMPTY: oValid=0.
  - HOLD: oValid=1; oData stable until accepted.
- Transfer occurs when oValid & iReady.
- Merged set M = P | iData. Selection: the highest set bit of M.
- Load condition: state is EMPTY, or a transfer occurs this cycle.
- On a load with M≠0:
  - oData ← index of highest bit of M; state → HOLD.
  - P ← M with the selected bit cleared.
- On a load with M=0: state → EMPTY; oData keeps its last value.
- No load (HOLD without transfer): P ← M; oData and oValid unchanged. There is no preemption by a higher-priority request.
- Coalescing: a bit already pending and requested again stays as a single pending entry.
- Re-request of the index currently held in HOLD sets its pending bit. It is served again after the current transfer.
- Index arithmetic: unsigned, IDX_W bits. WIDTH need not be a power of two; unused codes are never produced.

## Timing
- Reset values: oValid=0, oData=0, oPending=0, oErr=0, P=0, state EMPTY.
- Latency:
  - A request at cycle t with the block EMPTY: oValid=1 at cycle t+1.
  - In HOLD: the next index appears in the cycle after the transfer. Back-to-back transfers sustain 1 index per cycle.
- oPending reflects P after the edge. For example, a request cycle with iData=0x85 from EMPTY shows oPending=0x05 in the next cycle.
- Simultaneous transfer and new request: the new request participates in the same selection (M includes iData).
- Reset asserted mid-operation wins over all other activity:
  - P and the output register are cleared at that edge.
  - Requests presented during reset are dropped.
  - A held index that was not accepted is lost.
- Consumer rule: while oValid=1 and iReady=0, oData is stable.

## Configuration
- ENCODER_ONEHOT_CHECK_EN defined:
  - oErr registered; high for exactly one cycle following any cycle in which iData has more than one bit set.
  - The check is independent of the handshake and of reset-free operation.
  - oErr is cleared by reset.
- Not defined: oErr tied to 0 and no check logic is synthesised. The port still exists.

## Structure
- Shared package encoder_pkg:
  - constant function clog2_min1 (returns at least 1).
  - enum typedef for the FSM states EMPTY/HOLD.
- Sub-module prio_sel:
  - purely combinational.
  - parameter WIDTH.
  - input vector; outputs any (M≠0), idx (highest set bit) and onehot (mask of the selected bit, used to clear P).
- encoder_pend owns all registers.

## Test plan
- Reset: hold iRst=1 for 3 cycles with iData=0xFF. Required: oValid=0, oData=0, oPending=0, oErr=0 throughout; after release with iData=0, oValid stays 0.
- Single request: iData=0x20 for one cycle, iReady=1. Required: next cycle oValid=1, oData=5; the cycle after, oValid=0, oPending=0.
- Multi-hot order: iData=0x85 for one cycle, iReady=1. Required: oData = 7, 2, 0 on consecutive cycles with oPending = 0x05, 0x01, 0x00; then oValid=0.
- Backpressure with no preemption:
  - Stimulus: iReady=0; iData=0x10, then 0x80 one cycle later.
  - Required while iReady=0: oData holds 4; oPending=0x80.
  - After raising iReady: oData=4 accepted, then oData=7.
- Reset mid-operation: with P=0x0C and HOLD on index 6, assert iRst for one cycle. Required: oValid=0 and oPending=0 afterwards; no index 6, 3 or 2 is emitted.
- Error flag: iData=0x03 for one cycle.
  - With ENCODER_ONEHOT_CHECK_EN: oErr=1 for exactly one cycle.
  - Without the macro: oErr=0.
  - In both builds, indices 1 then 0 are emitted.
